// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Front end of the processor: owns the program counter, the instruction
// memory and the UART program loader that fills it.
//
// In LOAD mode the incoming byte stream is packed big-endian into 32-bit
// words. The first word is a header giving the number of program words
// that follow. Each program word k (1..N) lands in imem[k-1].
//
// In EXEC mode each instruction is fetched from memory and handed to the
// execute stage with a one-cycle start pulse. The block then waits a fixed
// number of cycles, plus any time the execute stage spends busy on UART
// I/O, and commits the next PC that execute presents. A jump to self is
// treated as the end of the program and parks the sequencer in HALT.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   mode        1 = LOAD, 2 = EXEC, anything else = idle
//   ld_valid    one-cycle strobe qualifying ld_byte
//   ld_byte     received program byte, most significant byte of a word first
//   npc         next PC from execute, sampled when the execute wait ends
//   uart_state  execute is busy on IN/OUT; holds off the commit
//   pc          byte address of the issued instruction
//   ir          issued instruction word, stable until commit
//   start       one-cycle pulse: ir/pc valid, execute begins
//   commit      one-cycle pulse: npc accepted into pc
//   load_done   level: header plus all N words written
//   load_err    sticky: header word count exceeded the memory depth
//   halted      level: self-loop (npc == pc) detected

module fetch_sequencer #(
    parameter int IMEM_AW   = 11,
    parameter int EXEC_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic [31:0] npc,
    input  logic        uart_state,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        start,
    output logic        commit,
    output logic        load_done,
    output logic        load_err,
    output logic        halted
);

    localparam int          DEPTH   = 1 << IMEM_AW;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam int          CW      = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        RDWAIT,
        ISSUE,
        EXEC,
        HALT
    } state_t;

    state_t state;
    state_t next_state;

    // Loader bookkeeping
    logic [1:0]         byte_cnt;
    logic [23:0]        word_sr;
    logic               hdr_seen;
    logic [31:0]        hdr_n;
    logic [31:0]        data_cnt;
    logic               wr_pend;
    logic               wr_ok;
    logic               wr_last;
    logic [IMEM_AW-1:0] wr_addr;
    logic [31:0]        wr_word;

    // Execute wait counter
    logic [CW-1:0]      wait_cnt;

    // Instruction memory
    logic [31:0]        imem [DEPTH];
    logic [31:0]        rd_data;
    logic [IMEM_AW-1:0] rd_addr;

    logic [31:0]        assembled;
    logic               take_byte;
    logic               enter_load;
    logic               wr_en;
    logic               exec_mode;
    logic               run_state;

    assign assembled = {word_sr, ld_byte};
    assign exec_mode = (mode == 3'd2);
    assign run_state = (state == FETCH) || (state == RDWAIT) || (state == ISSUE) ||
                       (state == EXEC)  || (state == HALT);

    // Once the header has been seen and N data words have arrived, the
    // stream is complete even though load_done lags one cycle behind the
    // final write, so stray bytes in that gap must not start a new word.
    assign take_byte = (state == LOAD) && ld_valid && !load_done &&
                       !(hdr_seen && (data_cnt == hdr_n));

    assign enter_load = (next_state == LOAD) && (state != LOAD);
    assign wr_en      = wr_pend && wr_ok;
    assign rd_addr    = pc[IMEM_AW+1:2];
    assign halted     = (state == HALT);

    // Next-state and strobe logic. The case statement handles the normal
    // sequence; the mode overrides afterwards let a mode change abort any
    // running state in one cycle and squash start/commit in that cycle.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (exec_mode && load_done) next_state = FETCH;
            end
            LOAD: begin
                if (exec_mode && load_done) next_state = FETCH;
                else if (mode != 3'd1)      next_state = IDLE;
            end
            FETCH:  next_state = RDWAIT;
            RDWAIT: next_state = ISSUE;
            ISSUE: begin
                start      = 1'b1;
                next_state = EXEC;
            end
            EXEC: begin
                if (wait_cnt == '0 && !uart_state) begin
                    if (npc == pc) begin
                        next_state = HALT;
                    end else begin
                        commit     = 1'b1;
                        next_state = FETCH;
                    end
                end
            end
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase

        if (run_state && !exec_mode) begin
            next_state = IDLE;
            start      = 1'b0;
            commit     = 1'b0;
        end
        if (mode == 3'd1) begin
            next_state = LOAD;
            start      = 1'b0;
            commit     = 1'b0;
        end
    end

    // State register, loader and PC/IR datapath. A completed data word is
    // staged for one cycle and written the following cycle; load_done is
    // raised together with the write of the last word so it becomes
    // visible one cycle after that write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            wait_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            byte_cnt  <= '0;
            word_sr   <= '0;
            hdr_seen  <= 1'b0;
            hdr_n     <= '0;
            data_cnt  <= '0;
            wr_pend   <= 1'b0;
            wr_ok     <= 1'b0;
            wr_last   <= 1'b0;
            wr_addr   <= '0;
            wr_word   <= '0;
        end else begin
            state   <= next_state;
            wr_pend <= 1'b0;

            if (enter_load) begin
                byte_cnt  <= '0;
                hdr_seen  <= 1'b0;
                data_cnt  <= '0;
                load_done <= 1'b0;
            end else begin
                if (wr_pend && wr_last) load_done <= 1'b1;
                if (take_byte) begin
                    word_sr  <= assembled[23:0];
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (!hdr_seen) begin
                            hdr_seen <= 1'b1;
                            hdr_n    <= assembled;
                            if (assembled == 32'd0)   load_done <= 1'b1;
                            if (assembled > DEPTH_W)  load_err  <= 1'b1;
                        end else begin
                            // Words past the end of memory are dropped rather
                            // than wrapped onto the start of the program.
                            data_cnt <= data_cnt + 32'd1;
                            wr_pend  <= 1'b1;
                            wr_ok    <= (data_cnt < DEPTH_W);
                            wr_last  <= ((data_cnt + 32'd1) == hdr_n);
                            wr_addr  <= data_cnt[IMEM_AW-1:0];
                            wr_word  <= assembled;
                        end
                    end
                end
            end

            if (enter_load)  pc <= '0;
            else if (commit) pc <= npc;

            if (state == RDWAIT) ir <= rd_data;

            if (state == ISSUE)
                wait_cnt <= CW'(EXEC_WAIT - 1);
            else if (state == EXEC && wait_cnt != '0)
                wait_cnt <= wait_cnt - CW'(1);
        end
    end

    // Block-RAM style memory with a registered read port. It is never
    // reset, so a program survives both reset and an empty reload.
    always_ff @(posedge clk) begin
        if (wr_en) imem[wr_addr] <= wr_word;
        rd_data <= imem[rd_addr];
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Drives program loads and instruction execution into fetch_sequencer and
// checks it against a behavioural model: a plain word array for memory, a
// model PC, and a per-instruction timing rule (start every commit + 3,
// commit EXEC_WAIT after start or one cycle after a long uart hold).
// Expected start/commit events go into queues; a negedge monitor pops and
// compares them whenever the DUT raises start or commit.

module tb_fetch_sequencer;

    localparam int IMEM_AW   = 11;
    localparam int EXEC_WAIT = 4;
    localparam int DEPTH     = 1 << IMEM_AW;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic [31:0] npc;
    logic        uart_state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        start;
    logic        commit;
    logic        load_done;
    logic        load_err;
    logic        halted;

    fetch_sequencer #(
        .IMEM_AW   (IMEM_AW),
        .EXEC_WAIT (EXEC_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .npc        (npc),
        .uart_state (uart_state),
        .pc         (pc),
        .ir         (ir),
        .start      (start),
        .commit     (commit),
        .load_done  (load_done),
        .load_err   (load_err),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] ir;
    } start_item_t;

    typedef struct {
        int          cyc;
        logic [31:0] npc;
    } commit_item_t;

    start_item_t  start_q[$];
    commit_item_t commit_q[$];

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_pc;
    logic        model_err;
    int          next_start;
    logic [31:0] ld_q[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One load byte presented for exactly one cycle.
    task automatic applyStimulus(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        step();
        ld_valid = 1'b0;
        ld_byte  = 8'($urandom);
    endtask

    // Monitor: compares every start/commit the DUT produces against the
    // scoreboard; the PC after a commit is checked one cycle later.
    start_item_t  mon_s;
    commit_item_t mon_c;
    logic         pc_chk_pending = 1'b0;
    logic [31:0]  pc_chk_val;

    always @(negedge clk) begin
        if (pc_chk_pending) begin
            checkOutput("pc_after_commit", pc, pc_chk_val);
            pc_chk_pending = 1'b0;
        end
        if (start === 1'b1) begin
            if (start_q.size() == 0) begin
                checkOutput("start_unexpected", {31'd0, start}, 32'd0);
            end else begin
                mon_s = start_q.pop_front();
                checkOutput("start_cycle", 32'(cyc), 32'(mon_s.cyc));
                checkOutput("start_pc", pc, mon_s.pc);
                checkOutput("start_ir", ir, mon_s.ir);
            end
        end
        if (commit === 1'b1) begin
            if (commit_q.size() == 0) begin
                checkOutput("commit_unexpected", {31'd0, commit}, 32'd0);
            end else begin
                mon_c = commit_q.pop_front();
                checkOutput("commit_cycle", 32'(cyc), 32'(mon_c.cyc));
                pc_chk_pending = 1'b1;
                pc_chk_val     = mon_c.npc;
            end
        end
    end

    // Loads the words in ld_q (header first) with random gaps between
    // bytes, checks load_done timing, then sends bytes that must be ignored.
    task automatic load_program(input int gap_max);
        logic [31:0] hdr;
        logic [31:0] w;
        hdr  = ld_q[0];
        mode = 3'd1;
        applyStimulus(8'($urandom));
        model_pc = 32'd0;
        checkOutput("load_entry_pc", pc, 32'd0);
        checkOutput("load_entry_done", {31'd0, load_done}, 32'd0);
        checkOutput("load_entry_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < ld_q.size(); i++) begin
            w = ld_q[i];
            for (int b = 3; b >= 0; b--) begin
                applyStimulus(w[8*b +: 8]);
                if (!(i == ld_q.size() - 1 && b == 0))
                    repeat ($urandom_range(gap_max, 0)) step();
            end
            if (i > 0 && i <= DEPTH) model_mem[i-1] = w;
        end
        if (hdr > 32'(DEPTH)) model_err = 1'b1;
        if (hdr == 32'd0) begin
            checkOutput("load_done_hdr0", {31'd0, load_done}, 32'd1);
        end else begin
            checkOutput("load_done_early", {31'd0, load_done}, 32'd0);
            step();
            checkOutput("load_done", {31'd0, load_done}, 32'd1);
        end
        repeat (4) applyStimulus(8'($urandom));
        step();
        checkOutput("load_done_kept", {31'd0, load_done}, 32'd1);
        checkOutput("load_err", {31'd0, load_err}, {31'd0, model_err});
        checkOutput("load_pc", pc, 32'd0);
    endtask

    task automatic begin_exec();
        mode       = 3'd2;
        next_start = cyc + 3;
    endtask

    // Executes one instruction at model_pc. uart_state is held high for
    // 'hold' cycles after start; npc carries junk until the commit cycle.
    task automatic run_instr(input logic [31:0] target, input int hold);
        int           s;
        int           c;
        start_item_t  si;
        commit_item_t ci;
        s     = next_start;
        si.cyc = s;
        si.pc  = model_pc;
        si.ir  = model_mem[model_pc[IMEM_AW+1:2]];
        start_q.push_back(si);
        c = (hold >= EXEC_WAIT) ? s + hold + 1 : s + EXEC_WAIT;
        if (target != model_pc) begin
            ci.cyc = c;
            ci.npc = target;
            commit_q.push_back(ci);
        end
        while (cyc < s) step();
        npc        = $urandom;
        uart_state = 1'b0;
        while (cyc < c) begin
            step();
            uart_state = (cyc <= s + hold);
            npc        = (cyc == c) ? target : $urandom;
        end
        if (target == model_pc) begin
            step();
            checkOutput("halted", {31'd0, halted}, 32'd1);
        end else begin
            model_pc   = target;
            next_start = c + 3;
        end
    endtask

    function automatic logic [31:0] pick_target(input int words);
        logic [31:0] t;
        do begin
            t = (($urandom_range(1, 0) == 1) ? $urandom() : 32'd0) & 32'hFFFF_E000;
            t = t | (32'($urandom_range(words - 1, 0)) << 2);
        end while (t == model_pc);
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: run did not complete by cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        mode       = 3'd0;
        ld_valid   = 1'b0;
        ld_byte    = 8'd0;
        npc        = 32'd0;
        uart_state = 1'b0;
        model_err  = 1'b0;
        model_pc   = 32'd0;
        repeat (3) step();
        checkOutput("rst_pc", pc, 32'd0);
        checkOutput("rst_ir", ir, 32'd0);
        checkOutput("rst_start", {31'd0, start}, 32'd0);
        checkOutput("rst_commit", {31'd0, commit}, 32'd0);
        checkOutput("rst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("rst_load_err", {31'd0, load_err}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;

        // Bytes outside LOAD must not count towards a program.
        applyStimulus(8'hAB);
        step();
        checkOutput("idle_byte_ignored", {31'd0, load_done}, 32'd0);

        // Two-word program, then 0 -> 4 -> 0 -> self-loop.
        ld_q = '{32'd2, 32'h2001_0005, 32'h2002_0007};
        load_program(2);
        begin_exec();
        run_instr(32'd4, 0);
        run_instr(32'd0, 0);
        run_instr(32'd0, 0);
        repeat (10) step();
        checkOutput("halt_stays", {31'd0, halted}, 32'd1);

        // Sixteen random words, sequential steps, random jumps and holds.
        ld_q.delete();
        ld_q.push_back(32'd16);
        for (int i = 0; i < 16; i++) ld_q.push_back($urandom);
        load_program(3);
        begin_exec();
        run_instr(32'd4, 0);
        run_instr(32'd8, 0);
        for (int k = 0; k < 6; k++)
            run_instr(pick_target(16), (k == 2) ? 20 : $urandom_range(6, 0));
        if (model_pc != 32'd8) run_instr(32'd8, $urandom_range(5, 0));
        run_instr(32'd8, 0);
        repeat (10) step();
        checkOutput("halt8_stays", {31'd0, halted}, 32'd1);

        // Empty program, then reset in the middle of EXEC.
        ld_q = '{32'd0};
        load_program(1);
        begin_exec();
        begin
            start_item_t si;
            si.cyc = next_start;
            si.pc  = model_pc;
            si.ir  = model_mem[0];
            start_q.push_back(si);
        end
        while (cyc < next_start + 1) step();
        rst  = 1'b1;
        mode = 3'd0;
        step();
        rst = 1'b0;
        model_pc  = 32'd0;
        model_err = 1'b0;
        checkOutput("midrst_pc", pc, 32'd0);
        checkOutput("midrst_ir", ir, 32'd0);
        checkOutput("midrst_start", {31'd0, start}, 32'd0);
        checkOutput("midrst_commit", {31'd0, commit}, 32'd0);
        checkOutput("midrst_load_done", {31'd0, load_done}, 32'd0);
        checkOutput("midrst_load_err", {31'd0, load_err}, 32'd0);
        checkOutput("midrst_halted", {31'd0, halted}, 32'd0);

        // Memory must survive the reset: run the old program again.
        ld_q = '{32'd0};
        load_program(1);
        begin_exec();
        run_instr(32'd60, 1);
        run_instr(32'd60, 0);

        // Oversized program: last word dropped, addresses alias by truncation.
        ld_q.delete();
        ld_q.push_back(32'(DEPTH + 1));
        for (int i = 0; i < DEPTH + 1; i++) ld_q.push_back($urandom);
        load_program(0);
        begin_exec();
        run_instr(32'(4 * DEPTH - 4), 0);
        run_instr(32'(4 * DEPTH), 0);
        run_instr(32'(4 * DEPTH), 0);

        repeat (5) step();
        checkOutput("start_q_drained", 32'(start_q.size()), 32'd0);
        checkOutput("commit_q_drained", 32'(commit_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
